// File: rtl/fwd_hazard_ctrl.sv
// EX operand forwarding selects (1-cycle registered) and load-use stall (combinational);
// pipe_hold freezes all state. Optional stall-cycle counter under FWD_STALL_CNT_EN.
module fwd_hazard_ctrl #(
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_hold,
  input  logic          ex_flush,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_dst,
  input  logic          id_regwrite,
  input  logic          id_memread,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          stall,
  output logic [15:0]   stall_count
);

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

  logic [RW-1:0] ex_dst;
  logic          ex_wr;
  logic          ex_ld;
  logic [RW-1:0] mem_dst;
  logic          mem_wr;

  logic [1:0]    sel_a;
  logic [1:0]    sel_b;
  logic          bubble;

  // The younger producer (now in EX, next in MEM) wins over the older one.
  function automatic logic [1:0] fwd_sel(
    input logic [RW-1:0] src,
    input logic [RW-1:0] e_dst,
    input logic          e_wr,
    input logic [RW-1:0] m_dst,
    input logic          m_wr
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (src != '0) begin
      if (e_wr && (e_dst == src))
        sel = SEL_EXMEM;
      else if (m_wr && (m_dst == src))
        sel = SEL_MEMWB;
    end
    return sel;
  endfunction

  always_comb begin
    stall = ex_ld && ex_wr && (ex_dst != '0) &&
            ((ex_dst == id_rs) || (ex_dst == id_rt));
  end

  always_comb begin
    sel_a  = fwd_sel(id_rs, ex_dst, ex_wr, mem_dst, mem_wr);
    sel_b  = fwd_sel(id_rt, ex_dst, ex_wr, mem_dst, mem_wr);
    bubble = ex_flush || stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_dst  <= '0;
      ex_wr   <= 1'b0;
      ex_ld   <= 1'b0;
      mem_dst <= '0;
      mem_wr  <= 1'b0;
      fwd_a   <= SEL_RF;
      fwd_b   <= SEL_RF;
    end else if (!pipe_hold) begin
      // MEM always advances; a stalled load still moves on and is forwarded from MEM/WB.
      mem_dst <= ex_dst;
      mem_wr  <= ex_wr;
      if (bubble) begin
        ex_dst <= '0;
        ex_wr  <= 1'b0;
        ex_ld  <= 1'b0;
        fwd_a  <= SEL_RF;
        fwd_b  <= SEL_RF;
      end else begin
        ex_dst <= id_dst;
        ex_wr  <= id_regwrite;
        ex_ld  <= id_memread;
        fwd_a  <= sel_a;
        fwd_b  <= sel_b;
      end
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (stall && !pipe_hold && !ex_flush && (stall_cnt_q != 16'hFFFF))
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed plus random bench for fwd_hazard_ctrl against an instruction-record pipeline model.
module tb_fwd_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst, pipe_hold, ex_flush;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic        id_regwrite, id_memread;
  logic [1:0]  fwd_a, fwd_b;
  logic        stall;
  logic [15:0] stall_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.RW(5)) dut (
    .clk(clk), .rst(rst), .pipe_hold(pipe_hold), .ex_flush(ex_flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .stall_count(stall_count)
  );

  // Model: the instruction records currently in EX and MEM, plus expected selects/count.
  typedef struct {
    int dst;
    bit wr;
    bit ld;
  } instr_t;

  instr_t m_ex, m_mem;
  int     m_fa, m_fb, m_cnt;
  bit     cnt_en;

  function automatic int src_sel(int r);
    if (r == 0) return 0;
    if (m_ex.wr && m_ex.dst == r) return 1;
    if (m_mem.wr && m_mem.dst == r) return 2;
    return 0;
  endfunction

  function automatic bit load_use(int rs, int rt);
    return m_ex.ld && m_ex.wr && m_ex.dst != 0 && (m_ex.dst == rs || m_ex.dst == rt);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit h, input bit f,
                            input int rs, input int rt, input int dst,
                            input bit wr, input bit ld);
    bit st;
    int sa, sb;
    if (r) begin
      m_ex = '{0, 0, 0};
      m_mem = '{0, 0, 0};
      m_fa = 0; m_fb = 0; m_cnt = 0;
    end else if (!h) begin
      st = load_use(rs, rt);
      sa = src_sel(rs);
      sb = src_sel(rt);
      if (cnt_en && st && !f && m_cnt < 65535) m_cnt++;
      m_mem = m_ex;
      if (f || st) begin
        m_ex = '{0, 0, 0};
        m_fa = 0; m_fb = 0;
      end else begin
        m_ex = '{dst, wr, ld};
        m_fa = sa; m_fb = sb;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit h, input bit f,
                       input int rs, input int rt, input int dst,
                       input bit wr, input bit ld, input bit chk_stall, input string tag);
    rst = r; pipe_hold = h; ex_flush = f;
    id_rs = 5'(rs); id_rt = 5'(rt); id_dst = 5'(dst);
    id_regwrite = wr; id_memread = ld;
    #1;
    if (chk_stall) chk({tag, ".stall"}, {15'd0, stall}, {15'd0, load_use(rs, rt)});
    @(posedge clk);
    model_edge(r, h, f, rs, rt, dst, wr, ld);
    #1;
    chk({tag, ".fwd_a"}, {14'd0, fwd_a}, 16'(m_fa));
    chk({tag, ".fwd_b"}, {14'd0, fwd_b}, 16'(m_fb));
    chk({tag, ".cnt"}, stall_count, 16'(m_cnt));
  endtask

  task automatic do_reset(input string tag);
    cycle(1, 0, 0, 9, 9, 9, 1, 1, 0, tag);
    cycle(1, 0, 0, 3, 4, 5, 1, 0, 0, tag);
  endtask

  initial begin
    logic [1:0] held_a, held_b;
    bit r, h, f, wr, ld;
`ifdef FWD_STALL_CNT_EN
    cnt_en = 1;
`else
    cnt_en = 0;
`endif
    m_ex = '{0, 0, 0}; m_mem = '{0, 0, 0};
    m_fa = 0; m_fb = 0; m_cnt = 0;

    do_reset("reset");
    chk("reset_fa", {14'd0, fwd_a}, 16'd0);
    chk("reset_stall", {15'd0, stall}, 16'd0);
    chk("reset_cnt", stall_count, 16'd0);

    // ALU -> ALU, back to back and with one nop between.
    cycle(0, 0, 0, 1, 2, 3, 1, 0, 1, "add3");
    cycle(0, 0, 0, 3, 3, 7, 1, 0, 1, "sub33");
    chk("exmem_a", {14'd0, fwd_a}, 16'd1);
    chk("exmem_b", {14'd0, fwd_b}, 16'd1);
    cycle(0, 0, 0, 1, 2, 3, 1, 0, 1, "add3b");
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, "nop");
    cycle(0, 0, 0, 3, 3, 7, 1, 0, 1, "sub33b");
    chk("memwb_a", {14'd0, fwd_a}, 16'd2);
    chk("memwb_b", {14'd0, fwd_b}, 16'd2);

    // Younger producer priority, then register 0.
    cycle(0, 0, 0, 1, 1, 5, 1, 0, 1, "p5a");
    cycle(0, 0, 0, 2, 2, 5, 1, 0, 1, "p5b");
    cycle(0, 0, 0, 5, 0, 8, 1, 0, 1, "c5");
    chk("prio_a", {14'd0, fwd_a}, 16'd1);
    chk("prio_b", {14'd0, fwd_b}, 16'd0);
    cycle(0, 0, 0, 1, 1, 0, 1, 0, 1, "p0");
    cycle(0, 0, 0, 0, 0, 9, 1, 0, 1, "c0");
    chk("zero_a", {14'd0, fwd_a}, 16'd0);

    // Load-use: one stall, then MEM/WB forward.
    do_reset("rst_lu");
    cycle(0, 0, 0, 1, 2, 4, 1, 1, 1, "lw4");
    chk("lu_stall_on", {15'd0, stall}, 16'd0);
    id_rs = 5'd1; id_rt = 5'd4; id_memread = 1'b0; #1;
    chk("lu_stall_pre", {15'd0, stall}, 16'd1);
    cycle(0, 0, 0, 1, 4, 6, 1, 0, 1, "add_rt4");
    chk("lu_bubble_a", {14'd0, fwd_a}, 16'd0);
    chk("lu_bubble_b", {14'd0, fwd_b}, 16'd0);
    chk("lu_stall_off", {15'd0, stall}, 16'd0);
    cycle(0, 0, 0, 1, 4, 6, 1, 0, 1, "add_rt4_again");
    chk("lu_fwd_a", {14'd0, fwd_a}, 16'd0);
    chk("lu_fwd_b", {14'd0, fwd_b}, 16'd2);
    chk("lu_cnt", stall_count, cnt_en ? 16'd1 : 16'd0);

    // Hold across a pending stall.
    do_reset("rst_hold");
    cycle(0, 0, 0, 1, 2, 4, 1, 1, 1, "lw4h");
    held_a = fwd_a; held_b = fwd_b;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 1, 4, 6, 1, 0, 1, "hold");
      chk("hold_stall", {15'd0, stall}, 16'd1);
      chk("hold_fa", {14'd0, fwd_a}, {14'd0, held_a});
      chk("hold_fb", {14'd0, fwd_b}, {14'd0, held_b});
      chk("hold_cnt", stall_count, 16'd0);
    end
    cycle(0, 0, 0, 1, 4, 6, 1, 0, 1, "release");
    chk("release_cnt", stall_count, cnt_en ? 16'd1 : 16'd0);
    cycle(0, 0, 0, 1, 4, 6, 1, 0, 1, "after_hold");
    chk("after_hold_b", {14'd0, fwd_b}, 16'd2);

    // Flush with load in EX and dependent in ID.
    do_reset("rst_flush");
    cycle(0, 0, 0, 1, 2, 4, 1, 1, 1, "lw4f");
    cycle(0, 0, 1, 4, 4, 6, 1, 0, 1, "flush");
    chk("flush_a", {14'd0, fwd_a}, 16'd0);
    chk("flush_b", {14'd0, fwd_b}, 16'd0);
    chk("flush_cnt", stall_count, 16'd0);
    cycle(0, 0, 0, 4, 1, 7, 1, 0, 1, "post_flush");
    chk("post_flush_a", {14'd0, fwd_a}, 16'd2);

    // Random traffic on a small register range so hazards are frequent.
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom % 60) == 0;
      h  = ($urandom % 6) == 0;
      f  = ($urandom % 8) == 0;
      ld = ($urandom % 3) == 0;
      wr = ld ? 1'b1 : (($urandom % 4) != 0);
      cycle(r, h, f, int'($urandom % 8), int'($urandom % 8), int'($urandom % 8),
            wr, ld, 1, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
